rx_frame_decoder: RTL and testbench

Byte-stream command decoder that sits directly downstream of the UART receiver `rx_module`. It consumes received bytes through the `RX_En_Sig` / `RX_Done_Sig` handshake and assembles fixed 4-byte frames. It validates header, command and checksum, then updates a held 8-bit result register (`Number_Data`) that drives the board LEDs. It replaces the simple echo-style control stage with framed, error-checked command handling.

---
 rtl/rx_frame_pkg.sv | 20 ++
 rtl/rx_timeout_counter.sv | 30 +++
 rtl/rx_frame_decoder.sv | 124 ++++++++++++
 tb/tb_rx_frame_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the framed UART command decoder.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_SUM
    } state_e;

    localparam logic [7:0] CMD_LOAD       = 8'h01;
    localparam logic [7:0] CMD_ADD        = 8'h02;
    localparam logic [7:0] CMD_CLEAR      = 8'h03;
    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_LOAD) || (cmd == CMD_ADD) || (cmd == CMD_CLEAR);
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter; expired pulses for one cycle when the count reaches its terminal value.
module rx_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned    W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic         hit;

    // clear has priority so a byte landing on the terminal cycle suppresses expiry
    assign hit     = run && !clear && (cnt_q == LAST);
    assign expired = hit;

    always_ff @(posedge clk) begin
        if (rst || clear || hit) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/rx_frame_decoder.sv
// Assembles HEADER/CMD/DATA/SUM frames from rx_module bytes and executes LOAD/ADD/CLEAR
// on the held Number_Data register, flagging and counting dropped frames.
module rx_frame_decoder
    import rx_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       CLOCK,
    input  logic       RST,
    input  logic       RX_Done_Sig,
    input  logic [7:0] RX_Data,
    output logic       RX_En_Sig,
    output logic [7:0] Number_Data,
    output logic       Frame_Valid_Sig,
    output logic       Frame_Err_Sig,
    output logic [7:0] Err_Count
);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] data_q, data_d;
    logic [7:0] num_q, num_d;
    logic [7:0] errcnt_q, errcnt_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       en_q, en_d;
    logic       accept;
    logic       expired;

    assign accept = RX_Done_Sig && en_q;

    rx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLOCK),
        .rst    (RST),
        .clear  (accept || (state_q == IDLE)),
        .run    (state_q != IDLE),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        num_d   = num_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        en_d    = !accept;

        case (state_q)
            IDLE: begin
                if (accept && (RX_Data == HEADER)) state_d = GET_CMD;
            end
            GET_CMD: begin
                if (accept) begin
                    cmd_d   = RX_Data;
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (accept) begin
                    data_d  = RX_Data;
                    state_d = GET_SUM;
                end
            end
            GET_SUM: begin
                if (accept) begin
                    state_d = IDLE;
                    if ((RX_Data == (HEADER ^ cmd_q ^ data_q)) && cmd_known(cmd_q)) begin
                        valid_d = 1'b1;
                        case (cmd_q)
                            CMD_LOAD:  num_d = data_q;
                            CMD_ADD:   num_d = num_q + data_q;
                            CMD_CLEAR: num_d = '0;
                            default:   num_d = num_q;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // expired is already masked by an accepted byte and only asserts outside IDLE
        if (expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end

        errcnt_d = (err_d && (errcnt_q != '1)) ? errcnt_q + 8'd1 : errcnt_q;
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            data_q   <= '0;
            num_q    <= '0;
            errcnt_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            num_q    <= num_d;
            errcnt_q <= errcnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            en_q     <= en_d;
        end
    end

    assign RX_En_Sig       = en_q;
    assign Number_Data     = num_q;
    assign Frame_Valid_Sig = valid_q;
    assign Frame_Err_Sig   = err_q;
    assign Err_Count       = errcnt_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: frame decode, errors, timeout, handshake and reset.
module tb_rx_frame_decoder;

    localparam int unsigned T = 100;

    logic       clk = 1'b0;
    logic       RST;
    logic       RX_Done_Sig;
    logic [7:0] RX_Data;
    logic       RX_En_Sig;
    logic [7:0] Number_Data;
    logic       Frame_Valid_Sig;
    logic       Frame_Err_Sig;
    logic [7:0] Err_Count;

    int vectors     = 0;
    int miscompares = 0;
    int vcnt        = 0;
    int ecnt        = 0;
    int bothcnt     = 0;

    rx_frame_decoder #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLOCK          (clk),
        .RST            (RST),
        .RX_Done_Sig    (RX_Done_Sig),
        .RX_Data        (RX_Data),
        .RX_En_Sig      (RX_En_Sig),
        .Number_Data    (Number_Data),
        .Frame_Valid_Sig(Frame_Valid_Sig),
        .Frame_Err_Sig  (Frame_Err_Sig),
        .Err_Count      (Err_Count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Frame_Valid_Sig) vcnt++;
        if (Frame_Err_Sig) ecnt++;
        if (Frame_Valid_Sig && Frame_Err_Sig) bothcnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (!RX_En_Sig && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("en_wait", RX_En_Sig, 1);
        RX_Done_Sig = 1'b1;
        RX_Data     = b;
        @(posedge clk); #1;
        RX_Done_Sig = 1'b0;
        check("ack_low", RX_En_Sig, 0);
    endtask

    task automatic frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic ok,
                         input logic [7:0] num, input logic [7:0] ec);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        check({tag, "_valid"}, Frame_Valid_Sig, ok);
        check({tag, "_err"}, Frame_Err_Sig, !ok);
        check({tag, "_num"}, Number_Data, num);
        check({tag, "_errcnt"}, Err_Count, ec);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {Frame_Valid_Sig, Frame_Err_Sig}, 2'b00);
    endtask

    initial begin
        int v0;
        int e0;
        int hit;

        RST         = 1'b1;
        RX_Done_Sig = 1'b0;
        RX_Data     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", RX_En_Sig, 0);
        check("rst_num", Number_Data, 8'h00);
        check("rst_valid", Frame_Valid_Sig, 0);
        check("rst_err", Frame_Err_Sig, 0);
        check("rst_errcnt", Err_Count, 8'h00);
        RST = 1'b0;
        @(posedge clk); #1;
        check("en_after_rst", RX_En_Sig, 1);

        frame("load5", 8'hAA, 8'h01, 8'h05, 8'hAE, 1'b1, 8'h05, 8'h00);
        frame("loadF0", 8'hAA, 8'h01, 8'hF0, 8'h5B, 1'b1, 8'hF0, 8'h00);
        frame("add_wrap", 8'hAA, 8'h02, 8'h20, 8'h88, 1'b1, 8'h10, 8'h00);
        frame("bad_sum", 8'hAA, 8'h01, 8'h05, 8'hAF, 1'b0, 8'h10, 8'h01);
        frame("bad_cmd", 8'hAA, 8'h07, 8'h00, 8'hAD, 1'b0, 8'h10, 8'h02);

        v0 = vcnt;
        e0 = ecnt;
        send_byte(8'h55);
        send_byte(8'h13);
        frame("junk_clear", 8'hAA, 8'h03, 8'h00, 8'hA9, 1'b1, 8'h00, 8'h02);
        check("junk_valid_pulses", vcnt - v0, 1);
        check("junk_err_pulses", ecnt - e0, 0);

        // Stall after AA 01: error pulse expected T clocks after the accepting edge.
        send_byte(8'hAA);
        send_byte(8'h01);
        hit = 0;
        for (int i = 1; i <= int'(T) + 10; i++) begin
            @(posedge clk); #1;
            if (Frame_Err_Sig) begin
                hit = i;
                break;
            end
        end
        check("timeout_cycle", hit, T);
        check("timeout_errcnt", Err_Count, 8'h03);
        check("timeout_num", Number_Data, 8'h00);
        @(posedge clk); #1;
        check("timeout_pulse_end", Frame_Err_Sig, 0);
        frame("after_timeout", 8'hAA, 8'h01, 8'h07, 8'hAC, 1'b1, 8'h07, 8'h03);

        // Byte accepted on the very edge the timeout would fire: byte wins.
        e0 = ecnt;
        send_byte(8'hAA);
        send_byte(8'h01);
        repeat (T - 1) begin
            @(posedge clk); #1;
        end
        send_byte(8'h09);
        check("tie_no_err", Frame_Err_Sig, 0);
        send_byte(8'hA2);
        check("tie_valid", Frame_Valid_Sig, 1);
        check("tie_num", Number_Data, 8'h09);
        check("tie_err_pulses", ecnt - e0, 0);
        check("tie_errcnt", Err_Count, 8'h03);
        @(posedge clk); #1;

        // RX_Done_Sig during the acknowledge cycle is ignored.
        send_byte(8'hAA);
        RX_Done_Sig = 1'b1;
        RX_Data     = 8'h77;
        @(posedge clk); #1;
        RX_Done_Sig = 1'b0;
        check("ack_done_ignored_en", RX_En_Sig, 1);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'hAE);
        check("ack_ignore_valid", Frame_Valid_Sig, 1);
        check("ack_ignore_num", Number_Data, 8'h05);
        @(posedge clk); #1;

        // Reset mid-frame.
        send_byte(8'hAA);
        send_byte(8'h01);
        RST = 1'b1;
        @(posedge clk); #1;
        check("midrst_en", RX_En_Sig, 0);
        check("midrst_num", Number_Data, 8'h00);
        check("midrst_errcnt", Err_Count, 8'h00);
        check("midrst_pulses", {Frame_Valid_Sig, Frame_Err_Sig}, 2'b00);
        RST = 1'b0;
        @(posedge clk); #1;
        frame("post_rst_add", 8'hAA, 8'h02, 8'h33, 8'h9B, 1'b1, 8'h33, 8'h00);

        for (int n = 0; n < 256; n++) begin
            send_byte(8'hAA);
            send_byte(8'h01);
            send_byte(8'h05);
            send_byte(8'hAF);
        end
        @(posedge clk); #1;
        check("sat_errcnt", Err_Count, 8'hFF);
        check("sat_num", Number_Data, 8'h33);
        check("never_both", bothcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
